// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide controller: op codes, FSM encoding,
// the unit request bundle and op-class helpers.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_MULT   = 3'd1,
        OP_MULTU  = 3'd2,
        OP_DIV    = 3'd3,
        OP_DIVU   = 3'd4,
        OP_MFHI   = 3'd5,
        OP_MFLO   = 3'd6,
        OP_MTHILO = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } muldiv_state_e;

    localparam int                 WDOG_W     = 6;
    localparam logic [WDOG_W-1:0]  WDOG_MAX   = 6'd63;
    localparam logic [31:0]        DIVZERO_LO = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        div;
        logic        sign;
    } unit_req_t;

    function automatic logic op_is_unit(input muldiv_op_e op);
        logic r;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_div(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Every op except NOP touches HI/LO or the unit, so all of them must wait on a busy FSM.
    function automatic logic op_uses_hilo(input muldiv_op_e op);
        return op != OP_NOP;
    endfunction

endpackage

// File: rtl/muldiv_wdog.sv
// Watchdog for the iterative unit: cleared on issue, counts while enabled,
// saturates at WDOG_MAX and flags expiry while still enabled.
module muldiv_wdog
    import muldiv_pkg::*;
(
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_clear,
    input  logic in_enable,
    output logic out_expired
);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (in_clear) begin
            cnt_d = '0;
        end else if (in_enable && (cnt_q != WDOG_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_expired = in_enable && (cnt_q == WDOG_MAX);

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: FSM, HI/LO registers and pipeline stall.
// MULDIV_DIVZERO_FAST_EN: divide by zero bypasses the unit (HI = rs, LO = all ones).
//
//   state | meaning
//   IDLE  | accepting ops; MTHI/MTLO write here
//   ISSUE | one-cycle start pulse to the unit
//   WAIT  | waiting for unit done, watchdog running
//   WB    | captured result loads HI/LO
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_ex_valid,
    input  logic [2:0]  in_ex_op,
    input  logic [31:0] in_ex_rs,
    input  logic [31:0] in_ex_rt,
    input  logic        in_unit_done,
    input  logic [31:0] in_unit_hi,
    input  logic [31:0] in_unit_lo,
    output logic        out_unit_start,
    output logic        out_unit_div,
    output logic        out_unit_sign,
    output logic [31:0] out_unit_a,
    output logic [31:0] out_unit_b,
    output logic [31:0] out_hi,
    output logic [31:0] out_lo,
    output logic        out_stall,
    output logic        out_err
);

    muldiv_state_e state_q, state_d;
    unit_req_t     req_q, req_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   res_hi_q, res_hi_d;
    logic [31:0]   res_lo_q, res_lo_d;
    logic          err_q, err_d;

    muldiv_op_e    ex_op;
    logic          wdog_clear;
    logic          wdog_en;
    logic          wdog_expired;

    assign ex_op = muldiv_op_e'(in_ex_op);

    assign wdog_en    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign wdog_clear = (state_q == ST_IDLE) && (state_d == ST_ISSUE);

    muldiv_wdog u_wdog (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_clear    (wdog_clear),
        .in_enable   (wdog_en),
        .out_expired (wdog_expired)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_ex_valid) begin
                    if (op_is_unit(ex_op)) begin
                        req_d.a    = in_ex_rs;
                        req_d.b    = in_ex_rt;
                        req_d.div  = op_is_div(ex_op);
                        req_d.sign = op_is_signed(ex_op);
`ifdef MULDIV_DIVZERO_FAST_EN
                        if (op_is_div(ex_op) && (in_ex_rt == '0)) begin
                            state_d  = ST_WB;
                            res_hi_d = in_ex_rs;
                            res_lo_d = DIVZERO_LO;
                        end else begin
                            state_d = ST_ISSUE;
                        end
`else
                        state_d = ST_ISSUE;
`endif
                    end else if (ex_op == OP_MTHILO) begin
                        if (in_ex_rt[0]) begin
                            lo_d = in_ex_rs;
                        end else begin
                            hi_d = in_ex_rs;
                        end
                    end
                end
            end

            // Done beats the watchdog when both land on the same cycle.
            ST_ISSUE, ST_WAIT: begin
                if (in_unit_done) begin
                    state_d  = ST_WB;
                    res_hi_d = in_unit_hi;
                    res_lo_d = in_unit_lo;
                end else if (wdog_expired) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_WB: begin
                hi_d    = res_hi_q;
                lo_d    = res_lo_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            err_q    <= err_d;
        end
    end

    assign out_unit_start = (state_q == ST_ISSUE);
    assign out_unit_div   = req_q.div;
    assign out_unit_sign  = req_q.sign;
    assign out_unit_a     = req_q.a;
    assign out_unit_b     = req_q.b;
    assign out_hi         = hi_q;
    assign out_lo         = lo_q;
    assign out_err        = err_q;
    assign out_stall      = (state_q != ST_IDLE) && in_ex_valid && op_uses_hilo(ex_op);

endmodule
